// File: rtl/exu_alu_arbt_if.sv
// Request, shared-datapath and result bus bundle for the EXU ALU arbiter.
interface exu_alu_arbt_if #(
   parameter int unsigned XLEN = 32
);
   // regular-ALU request
   logic            rglr_i_valid;
   logic            rglr_i_ready;
   logic [XLEN-1:0] rglr_i_op1;
   logic [XLEN-1:0] rglr_i_op2;
   logic            rglr_i_add;
   logic            rglr_i_lui;
   logic            rglr_i_ebreak;
   // address-generation request
   logic            agu_i_valid;
   logic            agu_i_ready;
   logic [XLEN-1:0] agu_i_op1;
   logic [XLEN-1:0] agu_i_op2;
   // shared ALU datapath
   logic            alu_req_alu_add;
   logic            alu_req_alu_lui;
   logic [XLEN-1:0] alu_req_alu_op1;
   logic [XLEN-1:0] alu_req_alu_op2;
   logic [XLEN-1:0] alu_req_alu_res;
   // results
   logic            rglr_o_valid;
   logic            rglr_o_ready;
   logic [XLEN-1:0] rglr_o_wdat;
   logic            rglr_o_ebreak;
   logic            agu_o_valid;
   logic            agu_o_ready;
   logic [XLEN-1:0] agu_o_addr;

   // arbiter side
   modport slave (
      input  rglr_i_valid, rglr_i_op1, rglr_i_op2, rglr_i_add, rglr_i_lui, rglr_i_ebreak,
      output rglr_i_ready,
      input  agu_i_valid, agu_i_op1, agu_i_op2,
      output agu_i_ready,
      output alu_req_alu_add, alu_req_alu_lui, alu_req_alu_op1, alu_req_alu_op2,
      input  alu_req_alu_res,
      output rglr_o_valid, rglr_o_wdat, rglr_o_ebreak,
      input  rglr_o_ready,
      output agu_o_valid, agu_o_addr,
      input  agu_o_ready
   );

   // requester / consumer / datapath side
   modport master (
      output rglr_i_valid, rglr_i_op1, rglr_i_op2, rglr_i_add, rglr_i_lui, rglr_i_ebreak,
      input  rglr_i_ready,
      output agu_i_valid, agu_i_op1, agu_i_op2,
      input  agu_i_ready,
      input  alu_req_alu_add, alu_req_alu_lui, alu_req_alu_op1, alu_req_alu_op2,
      output alu_req_alu_res,
      input  rglr_o_valid, rglr_o_wdat, rglr_o_ebreak,
      output rglr_o_ready,
      input  agu_o_valid, agu_o_addr,
      output agu_o_ready
   );
endinterface

// File: rtl/exu_alu_arbt.sv
// Round-robin arbiter sharing one ALU datapath between the regular ALU path
// and the AGU, with a single-entry result buffer that allows back-to-back ops.
module exu_alu_arbt #(
   parameter int unsigned XLEN = 32
) (
   input logic             clk,
   input logic             rst_n,
   exu_alu_arbt_if.slave   bus
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic OWN_RGLR = 1'b0;
   localparam logic OWN_AGU  = 1'b1;

   state_t          state;
   logic            owner;
   logic            last_grant;
   logic            ebreak_buf;
   logic [XLEN-1:0] data_buf;

   logic            rglr_out_valid;
   logic            agu_out_valid;
   logic            drain;
   logic            free;
   logic            gnt_rglr;
   logic            gnt_agu;

   // Buffer occupancy, drain detection and round-robin grant
   always_comb begin
      rglr_out_valid = (state == FULL) && (owner == OWN_RGLR);
      agu_out_valid  = (state == FULL) && (owner == OWN_AGU);
      drain          = (rglr_out_valid && bus.rglr_o_ready) ||
                       (agu_out_valid  && bus.agu_o_ready);
      free           = (state == EMPTY) || drain;
      gnt_rglr       = 1'b0;
      gnt_agu        = 1'b0;
      if (free) begin
         if (bus.rglr_i_valid && bus.agu_i_valid) begin
            // tie goes to whoever did not win last time
            gnt_agu  = (last_grant == OWN_RGLR);
            gnt_rglr = (last_grant == OWN_AGU);
         end else begin
            gnt_rglr = bus.rglr_i_valid;
            gnt_agu  = bus.agu_i_valid;
         end
      end
   end

   // Steer the granted requester onto the shared datapath; idle drives zeros
   always_comb begin
      bus.alu_req_alu_add = 1'b0;
      bus.alu_req_alu_lui = 1'b0;
      bus.alu_req_alu_op1 = '0;
      bus.alu_req_alu_op2 = '0;
      if (gnt_rglr) begin
         bus.alu_req_alu_add = bus.rglr_i_add;
         bus.alu_req_alu_lui = bus.rglr_i_lui;
         bus.alu_req_alu_op1 = bus.rglr_i_op1;
         bus.alu_req_alu_op2 = bus.rglr_i_op2;
      end else if (gnt_agu) begin
         bus.alu_req_alu_add = 1'b1;
         bus.alu_req_alu_op1 = bus.agu_i_op1;
         bus.alu_req_alu_op2 = bus.agu_i_op2;
      end
   end

   // Handshake and result outputs decoded from the buffer registers
   always_comb begin
      bus.rglr_i_ready  = gnt_rglr;
      bus.agu_i_ready   = gnt_agu;
      bus.rglr_o_valid  = rglr_out_valid;
      bus.agu_o_valid   = agu_out_valid;
      bus.rglr_o_wdat   = data_buf;
      bus.agu_o_addr    = data_buf;
      bus.rglr_o_ebreak = ebreak_buf && rglr_out_valid;
   end

   // Result buffer state machine: capture on grant, empty on drain without refill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         owner      <= OWN_RGLR;
         last_grant <= OWN_AGU;
         ebreak_buf <= 1'b0;
         data_buf   <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (gnt_rglr || gnt_agu) begin
                  state <= FULL;
               end
            end
            FULL: begin
               if (drain && !(gnt_rglr || gnt_agu)) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
         if (gnt_rglr || gnt_agu) begin
            owner      <= gnt_agu ? OWN_AGU : OWN_RGLR;
            last_grant <= gnt_agu ? OWN_AGU : OWN_RGLR;
            data_buf   <= bus.alu_req_alu_res;
            ebreak_buf <= gnt_rglr && bus.rglr_i_ebreak;
         end
      end
   end
endmodule

// File: doc/exu_alu_arbt.md
EXU_ALU_ARBT -- requirements
Module: exu_alu_arbt

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands and results.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rglr_i_valid / rglr_i_ready  input/output  1/1  regular-ALU request handshake.
REQ-005 rglr_i_op1, rglr_i_op2  input  XLEN  regular-ALU operands.
REQ-006 rglr_i_add, rglr_i_lui, rglr_i_ebreak  input  1 each  regular-ALU operation select and ebreak flag.
REQ-007 agu_i_valid / agu_i_ready  input/output  1/1  address-generation request handshake.
REQ-008 agu_i_op1, agu_i_op2  input  XLEN  AGU base and offset; AGU always requests add.
REQ-009 alu_req_alu_add, alu_req_alu_lui  output  1 each  operation select to shared ALU datapath.
REQ-010 alu_req_alu_op1, alu_req_alu_op2  output  XLEN  operands to shared ALU datapath.
REQ-011 alu_req_alu_res  input  XLEN  combinational result of the shared datapath, same cycle.
REQ-012 rglr_o_valid / rglr_o_ready  output/input  1/1  regular result handshake; rglr_o_wdat output XLEN; rglr_o_ebreak output 1.
REQ-013 agu_o_valid / agu_o_ready  output/input  1/1  AGU result handshake; agu_o_addr output XLEN.

Function
REQ-014 Block SHALL hold one result buffer with states EMPTY and FULL, plus a 1-bit owner (RGLR/AGU) and a 1-bit last-grant pointer.
REQ-015 Buffer SHALL be "free" when EMPTY, or FULL and the owning output handshake (o_valid & o_ready) completes this cycle.
REQ-016 When free and exactly one requester is valid, that requester SHALL be granted.
REQ-017 When free and both valid, the requester not named by last-grant SHALL be granted (round-robin).
REQ-018 When not free, no requester SHALL be granted.
REQ-019 rglr_i_ready / agu_i_ready SHALL equal the respective grant; ready SHALL NOT depend on that requester's own valid except via arbitration.
REQ-020 Granted requester SHALL drive alu_req_alu_op1/op2; add/lui from rglr_i_add/rglr_i_lui for RGLR, add=1/lui=0 for AGU.
REQ-021 With no grant, alu_req_alu_op1/op2 SHALL be 0 and add/lui SHALL be 0.
REQ-022 On grant, next edge SHALL capture alu_req_alu_res into the buffer, set owner, set FULL, update last-grant; ebreak captured for RGLR, cleared for AGU.
REQ-023 Output handshake without new grant SHALL move FULL->EMPTY; handshake with new grant SHALL keep FULL with new contents (back-to-back, no bubble).
REQ-024 rglr_o_valid SHALL be FULL & owner==RGLR; agu_o_valid SHALL be FULL & owner==AGU; invalid-owner ready SHALL be ignored.
REQ-025 rglr_o_wdat and agu_o_addr SHALL both present buffer data; rglr_o_ebreak SHALL be buffered ebreak & rglr_o_valid.
REQ-026 Latency SHALL be exactly one cycle from input handshake to output valid; sustained throughput one op per cycle with ready held high.
REQ-027 Buffered data, owner and ebreak SHALL remain stable while FULL and not drained.

Reset
REQ-028 rst_n low SHALL immediately force EMPTY, owner=RGLR, ebreak=0, data=0, last-grant=AGU (RGLR wins first tie).
REQ-029 During reset all o_valid SHALL be 0; i_ready follows REQ-016..019 combinationally from EMPTY state.
REQ-030 Reset asserted mid-operation SHALL discard the buffered result; no output handshake for it after release.

Verification
REQ-031 Only rglr_i_valid=1, op1=5, op2=7, add=1, res=12 -> rglr_i_ready=1 same cycle; next cycle rglr_o_valid=1, rglr_o_wdat=12.
REQ-032 Both valid every cycle, both o_ready=1, from reset -> grants RGLR, AGU, RGLR, AGU; one result per cycle, no idle cycle.
REQ-033 AGU result buffered, agu_o_ready=0 for 3 cycles, rglr_i_valid=1 -> rglr_i_ready=0 for those 3 cycles; agu_o_addr stable; RGLR granted on the drain cycle.
REQ-034 rglr_i_ebreak=1 granted -> next cycle rglr_o_ebreak=1; following AGU grant -> rglr_o_ebreak=0, agu_o_valid=1.
REQ-035 Buffer FULL, rst_n pulsed low between edges -> outputs invalid immediately; after release first tie grants RGLR.
